pipeline_control_unit: RTL and testbench

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/pipeline_control_unit.sv | 132 +++++++++++++
 tb/tb_pipeline_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Hazard and memory-wait controller for a five-stage pipeline: load-use bubbles, branch
// flushes and bounded memory stalls with a timeout abort. It also keeps saturating stall/flush counters.
module pipeline_control_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       RD_E,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

  localparam logic [15:0]      TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [15:0]      WAIT_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu_hazard;
  logic w_mem_stall;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_timeout;

  assign w_lu_hazard = MemReadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
  assign w_mem_stall = MemReqM & ~MemReadyM;

  // Outputs are combinational so stalls assert in the hazard cycle and release in the ready cycle.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_timeout = 1'b0;
    if (!rst) begin
      if (r_state == ABORT) begin
        w_timeout = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_mem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
      end else if (PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_lu_hazard) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_ONE;
          end
        end
        MEM_WAIT: begin
          if (!w_mem_stall) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TIMEOUT_W) begin
            r_state    <= ABORT;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        ABORT: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign StallF      = w_stall_f;
  assign StallD      = w_stall_d;
  assign StallE      = w_stall_e;
  assign StallM      = w_stall_m;
  assign FlushD      = w_flush_d;
  assign FlushE      = w_flush_e;
  assign mem_timeout = w_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed and randomized checks of pipeline_control_unit against a cycle-level model
// built from consecutive-stall counting and saturating event tallies.
module tb_pipeline_control_unit;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk;
  logic          rst;
  logic [4:0]    Rs1_D, Rs2_D, RD_E;
  logic          MemReadE, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    outs;

  int tests = 0;
  int fails = 0;

  // Model: number of consecutive stalled cycles in the current wait, pending abort, tallies.
  int m_run   = 0;
  bit m_abort = 0;
  int m_sc    = 0;
  int m_fc    = 0;

  pipeline_control_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_abort = 0; m_sc = 0; m_fc = 0;
  endtask

  // One cycle: drive after the falling edge, check mid-low phase, advance model for the next rising edge.
  task automatic tick(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mre, input logic pcs,
                      input logic req, input logic rdy);
    logic [6:0] exp_o;
    logic ms, lu;
    @(negedge clk);
    rst = r; Rs1_D = rs1; Rs2_D = rs2; RD_E = rd;
    MemReadE = mre; PCSrcE = pcs; MemReqM = req; MemReadyM = rdy;
    #1;
    ms = req & ~rdy;
    lu = mre && (rd != 0) && ((rd == rs1) || (rd == rs2));
    exp_o = 7'b0;
    if (!r) begin
      if (m_abort)  exp_o = 7'b0000011;
      else if (ms)  exp_o = 7'b1111000;
      else if (pcs) exp_o = 7'b0000110;
      else if (lu)  exp_o = 7'b1100010;
    end
    check("outs", 32'(outs), 32'(exp_o));
    check("stall_cnt", 32'(stall_cnt), r ? 32'd0 : 32'(m_sc));
    check("flush_cnt", 32'(flush_cnt), r ? 32'd0 : 32'(m_fc));
    $display("[TB] t=%0t rst=%0b rs1=%0d rs2=%0d rd=%0d mre=%0b pcs=%0b req=%0b rdy=%0b outs=%b sc=%0d fc=%0d",
             $time, r, rs1, rs2, rd, mre, pcs, req, rdy, outs, stall_cnt, flush_cnt);
    if (r) begin
      model_reset();
    end else begin
      if (exp_o[6] && m_sc < SAT) m_sc++;
      if ((exp_o[2] || exp_o[1]) && m_fc < SAT) m_fc++;
      if (m_abort) begin
        m_abort = 0;
        m_run   = 0;
      end else if (ms) begin
        m_run++;
        if (m_run == TO + 1) begin
          m_abort = 1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin
    int fc0;
    rst = 1'b1; Rs1_D = '0; Rs2_D = '0; RD_E = '0;
    MemReadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;

    // Reset state with hazard-looking inputs still held off.
    tick(1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 0);
    check("rst_outs", 32'(outs), 32'd0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);

    // Load-use: one bubble, one stall counted.
    tick(0, 5'd0, 5'd5, 5'd5, 1, 0, 0, 0);
    check("lu_outs", 32'(outs), 32'b1100010);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_once", 32'(outs), 32'd0);
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    // x0 destination never hazards.
    tick(0, 5'd0, 5'd7, 5'd0, 1, 0, 0, 0);
    check("x0_outs", 32'(outs), 32'd0);

    // Branch beats load-use.
    fc0 = m_fc;
    tick(0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0);
    check("br_outs", 32'(outs), 32'b0000110);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    check("br_fcnt", 32'(flush_cnt), 32'(fc0 + 1));

    // Memory wait of three cycles, released on ready.
    for (int i = 0; i < 3; i++) begin
      tick(0, 5'd1, 5'd2, 5'd1, 1, 1, 1, 0);
      check("mw_stall", 32'(outs), 32'b1111000);
    end
    tick(0, 0, 0, 0, 0, 0, 1, 1);
    check("mw_ready", 32'(outs), 32'd0);
    tick(0, 5'd1, 5'd2, 5'd1, 1, 0, 0, 0);
    check("mw_run", 32'(outs), 32'b1100010);

    // Timeout: five stalled cycles then a one-cycle abort.
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0, 1, 0);
      check("to_stall", 32'(outs), 32'b1111000);
    end
    tick(0, 5'd3, 5'd3, 5'd3, 1, 1, 1, 0);
    check("to_abort", 32'(outs), 32'b0000011);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    check("to_after", 32'(outs), 32'd0);

    // Asynchronous reset mid-wait with seven stalls counted.
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    check("ar_pre_cnt", 32'(stall_cnt), 32'd7);
    check("ar_pre_outs", 32'(outs), 32'b1111000);
    rst = 1'b1;
    #1;
    check("ar_outs", 32'(outs), 32'd0);
    check("ar_scnt", 32'(stall_cnt), 32'd0);
    check("ar_fcnt", 32'(flush_cnt), 32'd0);
    model_reset();
    tick(1, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    check("ar_resume", 32'(outs), 32'd0);

    // Randomized traffic, including occasional resets and counter saturation.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 79) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
